notes_sequencer: RTL and testbench

Melody controller for the eight-buzzer note bank (C6 through C7). It replaces the free-running flip-flop counter and 3-to-8 decoder with a programmable sequencer. Each step of an 8-entry pattern memory drives exactly one buzzer, or none, for a programmed number of beats, with a one-cycle articulation gap between steps. It sits between the top-level control inputs and the buzzer outputs.

---
 rtl/notes_sequencer_if.sv | 25 ++
 rtl/notes_sequencer.sv | 116 +++++++++++
 tb/tb_notes_sequencer.sv | 180 ++++++++++++++++++
 3 files changed

// File: rtl/notes_sequencer_if.sv
// Control, pattern-write and buzzer signals of the melody sequencer.
// The bench drives through master; the sequencer uses slave.
interface notes_sequencer_if;
    logic       start;
    logic       stop;
    logic       loop;
    logic [2:0] seq_len;
    logic       wr_en;
    logic [2:0] wr_addr;
    logic [5:0] wr_data;
    logic [7:0] buzzer;
    logic       busy;
    logic [2:0] step_idx;
    logic       done;

    modport master (
        output start, stop, loop, seq_len, wr_en, wr_addr, wr_data,
        input  buzzer, busy, step_idx, done
    );

    modport slave (
        input  start, stop, loop, seq_len, wr_en, wr_addr, wr_data,
        output buzzer, busy, step_idx, done
    );
endinterface

// File: rtl/notes_sequencer.sv
// Programmable 8-step melody sequencer driving a one-hot bank of eight buzzers.
// Each step plays one note or a rest for (d+1) beats, followed by a one-cycle gap.
module notes_sequencer #(
    parameter int unsigned TICKS_PER_BEAT = 4
) (
    input logic              clk,
    input logic              reset,
    notes_sequencer_if.slave bus
);
    localparam int unsigned CntW = 10;

    typedef enum logic [1:0] {StIdle, StPlay, StGap} state_e;

    state_e              state_q, state_d;
    logic [5:0]          mem_q [8];
    logic [5:0]          cur_q, cur_d;
    logic [CntW-1:0]     cnt_q, cnt_d;
    logic [2:0]          step_q, step_d;
    logic [7:0]          buzzer_q, buzzer_d;
    logic                busy_q, busy_d;
    logic                done_q, done_d;
    logic                enter;
    logic [2:0]          next_step;

    function automatic logic [CntW-1:0] step_ticks(input logic [1:0] d);
        return CntW'((int'(d) + 1) * TICKS_PER_BEAT - 1);
    endfunction

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            for (int i = 0; i < 8; i++) mem_q[i] <= '0;
        end else if (bus.wr_en) begin
            mem_q[bus.wr_addr] <= bus.wr_data;
        end
    end

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            state_q  <= StIdle;
            cur_q    <= '0;
            cnt_q    <= '0;
            step_q   <= '0;
            buzzer_q <= '0;
            busy_q   <= 1'b0;
            done_q   <= 1'b0;
        end else begin
            state_q  <= state_d;
            cur_q    <= cur_d;
            cnt_q    <= cnt_d;
            step_q   <= step_d;
            buzzer_q <= buzzer_d;
            busy_q   <= busy_d;
            done_q   <= done_d;
        end
    end

    always_comb begin
        state_d   = state_q;
        cur_d     = cur_q;
        cnt_d     = cnt_q;
        step_d    = step_q;
        done_d    = 1'b0;
        enter     = 1'b0;
        next_step = step_q;

        unique case (state_q)
            StIdle: begin
                if (bus.start) begin
                    enter     = 1'b1;
                    next_step = 3'd0;
                end
            end
            StPlay: begin
                if (cnt_q == '0) state_d = StGap;
                else             cnt_d   = cnt_q - 1'b1;
            end
            StGap: begin
                if (step_q != bus.seq_len) begin
                    enter     = 1'b1;
                    next_step = step_q + 3'd1;
                end else if (bus.loop) begin
                    enter     = 1'b1;
                    next_step = 3'd0;
                end else begin
                    state_d = StIdle;
                    done_d  = 1'b1;
                end
            end
            default: state_d = StIdle;
        endcase

        // The entry is latched on step entry so later writes cannot disturb the note in progress.
        if (enter) begin
            state_d = StPlay;
            step_d  = next_step;
            cur_d   = mem_q[next_step];
            cnt_d   = step_ticks(mem_q[next_step][4:3]);
        end

        if (bus.stop) begin
            state_d = StIdle;
            step_d  = 3'd0;
            done_d  = 1'b0;
        end

        // Outputs are registered from next-state values so they track the state without lag.
        buzzer_d = '0;
        if (state_d == StPlay && !cur_d[5]) buzzer_d = 8'b1 << cur_d[2:0];
        busy_d = (state_d != StIdle);
    end

    assign bus.buzzer   = buzzer_q;
    assign bus.busy     = busy_q;
    assign bus.step_idx = step_q;
    assign bus.done     = done_q;
endmodule

// File: tb/tb_notes_sequencer.sv
// Directed self-checking bench for notes_sequencer with TICKS_PER_BEAT = 4.
module tb_notes_sequencer;
    logic clk;
    logic reset;
    int   n_checks;
    int   n_fail;

    notes_sequencer_if bus ();

    notes_sequencer #(
        .TICKS_PER_BEAT(4)
    ) dut (
        .clk  (clk),
        .reset(reset),
        .bus  (bus)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_checks++;
        if (got !== exp) begin
            n_fail++;
            $display("FAIL %s: got 0x%0h expected 0x%0h", tag, got, exp);
        end
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic write_entry(input logic [2:0] addr, input logic [5:0] data);
        bus.wr_en   = 1'b1;
        bus.wr_addr = addr;
        bus.wr_data = data;
        tick();
        bus.wr_en   = 1'b0;
    endtask

    task automatic pulse_start();
        bus.start = 1'b1;
        tick();
        bus.start = 1'b0;
    endtask

    // Eight 1-beat steps, seq_len=7, no loop: each note 4 cycles, then a gap; done at cycle 40.
    task automatic run_seq8(input string tag, input bit all_c6);
        logic [7:0] exp_buz;
        int         st;
        for (int c = 0; c <= 40; c++) begin
            st      = c / 5;
            exp_buz = 8'h00;
            if (c < 40 && (c % 5) < 4) exp_buz = all_c6 ? 8'h01 : (8'h01 << st);
            check($sformatf("%s buzzer c%0d", tag, c), {24'd0, bus.buzzer}, {24'd0, exp_buz});
            check($sformatf("%s done c%0d", tag, c), {31'd0, bus.done}, {31'd0, c == 40});
            check($sformatf("%s busy c%0d", tag, c), {31'd0, bus.busy}, {31'd0, c < 40});
            if (c < 40)
                check($sformatf("%s step c%0d", tag, c), {29'd0, bus.step_idx}, st);
            tick();
        end
        check($sformatf("%s done clear", tag), {31'd0, bus.done}, 32'd0);
    endtask

    initial begin
        logic [7:0] exp_buz;
        int         st;
        int         note;
        n_checks    = 0;
        n_fail      = 0;
        bus.start   = 1'b0;
        bus.stop    = 1'b0;
        bus.loop    = 1'b0;
        bus.seq_len = 3'd0;
        bus.wr_en   = 1'b0;
        bus.wr_addr = 3'd0;
        bus.wr_data = 6'd0;
        reset       = 1'b1;
        #12;
        check("reset buzzer", {24'd0, bus.buzzer}, 32'd0);
        check("reset busy", {31'd0, bus.busy}, 32'd0);
        check("reset step", {29'd0, bus.step_idx}, 32'd0);
        check("reset done", {31'd0, bus.done}, 32'd0);
        @(posedge clk);
        #1;
        reset = 1'b0;
        tick();

        // Scale C6..C7
        for (int i = 0; i < 8; i++) write_entry(3'(i), 6'(i));
        bus.seq_len = 3'd7;
        pulse_start();
        run_seq8("scale", 1'b0);

        // Duration and rest
        write_entry(3'd0, 6'h1C);
        write_entry(3'd1, 6'h28);
        bus.seq_len = 3'd1;
        pulse_start();
        for (int c = 0; c <= 26; c++) begin
            exp_buz = (c < 16) ? 8'h10 : 8'h00;
            check($sformatf("dur buzzer c%0d", c), {24'd0, bus.buzzer}, {24'd0, exp_buz});
            check($sformatf("dur busy c%0d", c), {31'd0, bus.busy}, {31'd0, c < 26});
            check($sformatf("dur done c%0d", c), {31'd0, bus.done}, {31'd0, c == 26});
            if (c < 26)
                check($sformatf("dur step c%0d", c), {29'd0, bus.step_idx}, (c <= 16) ? 0 : 1);
            tick();
        end

        // Loop, wrap and live write to the step in progress
        for (int i = 0; i < 3; i++) write_entry(3'(i), 6'(i));
        bus.seq_len = 3'd2;
        bus.loop    = 1'b1;
        pulse_start();
        for (int c = 0; c <= 30; c++) begin
            st      = (c / 5) % 3;
            note    = (st == 1 && c >= 15) ? 7 : st;
            exp_buz = (c < 30 && (c % 5) < 4) ? (8'h01 << note) : 8'h00;
            check($sformatf("loop buzzer c%0d", c), {24'd0, bus.buzzer}, {24'd0, exp_buz});
            check($sformatf("loop done c%0d", c), {31'd0, bus.done}, {31'd0, c == 30});
            if (c < 30)
                check($sformatf("loop step c%0d", c), {29'd0, bus.step_idx}, st);
            bus.wr_en   = (c == 6);
            bus.wr_addr = 3'd1;
            bus.wr_data = 6'd7;
            if (c == 26) bus.loop = 1'b0;
            tick();
        end
        bus.wr_en = 1'b0;

        // Stop/start collisions
        bus.start = 1'b1;
        bus.stop  = 1'b1;
        tick();
        bus.start = 1'b0;
        bus.stop  = 1'b0;
        check("collide busy", {31'd0, bus.busy}, 32'd0);
        check("collide buzzer", {24'd0, bus.buzzer}, 32'd0);
        pulse_start();
        check("play buzzer", {24'd0, bus.buzzer}, 32'h01);
        tick();
        pulse_start();
        check("restart step", {29'd0, bus.step_idx}, 32'd0);
        check("restart buzzer", {24'd0, bus.buzzer}, 32'h01);
        check("restart busy", {31'd0, bus.busy}, 32'd1);
        bus.stop = 1'b1;
        tick();
        bus.stop = 1'b0;
        check("stop busy", {31'd0, bus.busy}, 32'd0);
        check("stop buzzer", {24'd0, bus.buzzer}, 32'd0);
        check("stop done", {31'd0, bus.done}, 32'd0);
        tick();
        check("stop done later", {31'd0, bus.done}, 32'd0);
        check("stop stays idle", {31'd0, bus.busy}, 32'd0);

        // Reset mid-play clears outputs at once and wipes the pattern memory
        for (int i = 0; i < 8; i++) write_entry(3'(i), 6'h0D);
        bus.seq_len = 3'd7;
        pulse_start();
        tick();
        check("pre-reset buzzer", {24'd0, bus.buzzer}, 32'h20);
        check("pre-reset busy", {31'd0, bus.busy}, 32'd1);
        reset = 1'b1;
        #1;
        check("async buzzer", {24'd0, bus.buzzer}, 32'd0);
        check("async busy", {31'd0, bus.busy}, 32'd0);
        check("async step", {29'd0, bus.step_idx}, 32'd0);
        @(posedge clk);
        #1;
        reset = 1'b0;
        tick();
        check("post-reset idle", {31'd0, bus.busy}, 32'd0);
        pulse_start();
        run_seq8("cleared", 1'b1);

        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end
endmodule
